// File: rtl/stream_width_upsizer.sv
// -----------------------------------------------------------------------------
// stream_width_upsizer
//
// Packs RATIO consecutive IN_WIDTH-bit beats (little-endian: beat k lands in
// bits [k*IN_WIDTH +: IN_WIDTH]) into one OUT_WIDTH = IN_WIDTH*RATIO word and
// queues it in a FIFO_DEPTH-entry FIFO behind a valid/ready output. The input
// cannot be stalled, so a word completing into a full FIFO (with no pop on the
// same edge) is dropped and counted.
//
// Parameters:
//   IN_WIDTH   input beat width (default 16)
//   RATIO      beats per output word, 2..8 (default 2)
//   FIFO_DEPTH FIFO entries, power of 2, >= 2 (default 4)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    input beat data
//   in_valid   input beat qualifier, never stalled
//   flush      abandon the partial word held before this cycle's beat
//   out_data   word at the FIFO head (registered)
//   out_valid  FIFO non-empty (registered)
//   out_ready  downstream accepts the head word
//   overflow   sticky: a completed word was dropped
//   drop_cnt   dropped-word count, saturating at 255
//
// Build option:
//   STREAM_UPSIZER_PARTIAL_FLUSH_EN - when defined, a flush with a non-empty
//   partial word pushes it (upper beats zero) under the normal full rules;
//   when undefined the partial word is silently discarded.
// -----------------------------------------------------------------------------
module stream_width_upsizer #(
    parameter int IN_WIDTH   = 16,
    parameter int RATIO      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IN_WIDTH-1:0]          in_data,
    input  logic                         in_valid,
    input  logic                         flush,
    output logic [IN_WIDTH*RATIO-1:0]    out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow,
    output logic [7:0]                   drop_cnt
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int IDXW      = $clog2(RATIO);
    localparam int PTRW      = $clog2(FIFO_DEPTH);
    localparam int CNTW      = PTRW + 1;

    localparam logic [IDXW-1:0] C_IDX_ZERO = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] C_IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] C_IDX_LAST = IDXW'(RATIO - 1);
    localparam logic [PTRW-1:0] C_PTR_ZERO = {PTRW{1'b0}};
    localparam logic [PTRW-1:0] C_PTR_ONE  = PTRW'(1);
    localparam logic [CNTW-1:0] C_CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] C_CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] C_CNT_FULL = CNTW'(FIFO_DEPTH);

    logic [IDXW-1:0]      r_idx;
    logic [OUT_WIDTH-1:0] r_asm;
    logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTRW-1:0]      r_wptr;
    logic [PTRW-1:0]      r_rptr;
    logic [CNTW-1:0]      r_count;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic                 r_out_valid;
    logic                 r_overflow;
    logic [7:0]           r_drop_cnt;

    logic [IDXW-1:0]      w_idx_base;
    logic [OUT_WIDTH-1:0] w_asm_base;
    logic [OUT_WIDTH-1:0] w_word;
    logic                 w_last;
    logic [IDXW-1:0]      w_idx_nxt;
    logic [OUT_WIDTH-1:0] w_asm_nxt;
    logic                 w_flush_push;
    logic                 w_push_req;
    logic [OUT_WIDTH-1:0] w_push_data;
    logic                 w_pop;
    logic                 w_push_ok;
    logic                 w_drop;
    logic [CNTW-1:0]      w_cnt_after_pop;
    logic [CNTW-1:0]      w_count_nxt;
    logic [PTRW-1:0]      w_rptr_nxt;
    logic [PTRW-1:0]      w_wptr_nxt;
    logic [OUT_WIDTH-1:0] w_head_nxt;

    // Beat assembly: flush is applied before this cycle's beat is merged.
    always_comb begin
        w_idx_base = r_idx;
        w_asm_base = r_asm;
        if (flush) begin
            w_idx_base = C_IDX_ZERO;
            w_asm_base = {OUT_WIDTH{1'b0}};
        end else begin
            w_idx_base = r_idx;
            w_asm_base = r_asm;
        end

        w_word = w_asm_base;
        for (int k = 0; k < RATIO; k++) begin
            if (w_idx_base == IDXW'(k)) begin
                w_word[k*IN_WIDTH +: IN_WIDTH] = in_data;
            end else begin
                w_word[k*IN_WIDTH +: IN_WIDTH] = w_asm_base[k*IN_WIDTH +: IN_WIDTH];
            end
        end

        w_last = in_valid && (w_idx_base == C_IDX_LAST);

        w_idx_nxt = w_idx_base;
        w_asm_nxt = w_asm_base;
        if (w_last) begin
            w_idx_nxt = C_IDX_ZERO;
            w_asm_nxt = {OUT_WIDTH{1'b0}};
        end else if (in_valid) begin
            w_idx_nxt = w_idx_base + C_IDX_ONE;
            w_asm_nxt = w_word;
        end else begin
            w_idx_nxt = w_idx_base;
            w_asm_nxt = w_asm_base;
        end
    end

    // Push / pop decisions and next FIFO bookkeeping.
    always_comb begin
`ifdef STREAM_UPSIZER_PARTIAL_FLUSH_EN
        // r_asm only ever holds filled beats, so upper beats are already zero.
        w_flush_push = flush && (r_idx != C_IDX_ZERO);
`else
        w_flush_push = 1'b0;
`endif
        // A normal push needs base index RATIO-1, which flush forces to 0,
        // so the two push sources never coincide.
        w_push_req = w_last || w_flush_push;
        if (w_last) begin
            w_push_data = w_word;
        end else begin
            w_push_data = r_asm;
        end

        w_pop     = r_out_valid && out_ready;
        w_push_ok = w_push_req && ((r_count != C_CNT_FULL) || w_pop);
        w_drop    = w_push_req && !w_push_ok;

        w_cnt_after_pop = r_count - (w_pop ? C_CNT_ONE : C_CNT_ZERO);
        w_count_nxt     = w_cnt_after_pop + (w_push_ok ? C_CNT_ONE : C_CNT_ZERO);
        w_rptr_nxt      = r_rptr + (w_pop ? C_PTR_ONE : C_PTR_ZERO);
        w_wptr_nxt      = r_wptr + (w_push_ok ? C_PTR_ONE : C_PTR_ZERO);

        // Head after this edge: the word being written if the FIFO is
        // otherwise empty, else the stored entry at the new read pointer.
        if (w_count_nxt == C_CNT_ZERO) begin
            w_head_nxt = {OUT_WIDTH{1'b0}};
        end else if (w_cnt_after_pop == C_CNT_ZERO) begin
            w_head_nxt = w_push_data;
        end else begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    // State registers: assembly, FIFO storage/pointers, output and drop status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= C_IDX_ZERO;
            r_asm       <= {OUT_WIDTH{1'b0}};
            r_wptr      <= C_PTR_ZERO;
            r_rptr      <= C_PTR_ZERO;
            r_count     <= C_CNT_ZERO;
            r_out_data  <= {OUT_WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= 8'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {OUT_WIDTH{1'b0}};
            end
        end else begin
            r_idx       <= w_idx_nxt;
            r_asm       <= w_asm_nxt;
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_count     <= w_count_nxt;
            r_out_data  <= w_head_nxt;
            r_out_valid <= (w_count_nxt != C_CNT_ZERO);
            if (w_push_ok) begin
                r_mem[r_wptr] <= w_push_data;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'd255) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule
